i2c_master_arbiter: RTL
=======================

// Module: i2c_master_arbiter
// PURPOSE
//  Round-robin arbiter that shares one i2c_master command/write-data/read-data stream set among PORTS requesters.
//  A requester holds the grant for a whole bus transaction and loses it once its stop command is accepted and the
//  master goes idle. A watchdog reclaims a grant from a stalled owner by issuing a stop-only command.
// PARAMETERS
//  PORTS    4     number of requesters (>=2); PW=$clog2(PORTS) internal
//  TIMEOUT  1024  idle cycles in GRANT before reclaim; 0 disables watchdog
// PORTS
//  clk                       in   1         single clock, all logic rising-edge
//  rst_n                     in   1         asynchronous, active-low reset
//  s_cmd_address             in   PORTS*7   per-port slave address, port i at [7i+:7]
//  s_cmd_start/read/write/write_multiple/stop  in  PORTS each  per-port command flags
//  s_cmd_valid / s_cmd_ready in/out PORTS   per-port command handshake
//  s_wr_tdata                in   PORTS*8   per-port write data
//  s_wr_tvalid/s_wr_tlast    in   PORTS     per-port write valid/last
//  s_wr_tready               out  PORTS     per-port write ready
//  m_rd_tdata / m_rd_tlast   out  8 / 1     read data, broadcast to all ports
//  m_rd_tvalid / m_rd_tready out/in PORTS   per-port read handshake
//  m_cmd_address             out  7         command to i2c_master
//  m_cmd_start/read/write/write_multiple/stop out 1 each
//  m_cmd_valid / m_cmd_ready out/in 1
//  m_wr_tdata/tvalid/tlast   out  8/1/1     write data to master; m_wr_tready in 1
//  s_rd_tdata/tvalid/tlast   in   8/1/1     read data from master; s_rd_tready out 1
//  master_busy               in   1         i2c_master busy
//  grant                     out  PORTS     one-hot current owner, 0 when unowned
//  timeout_evt               out  1         1-cycle pulse on watchdog reclaim
// BEHAVIOUR
//  Reset: state=IDLE, grant=0, rr_last=PORTS-1 (port 0 highest priority first), timer=0, cmd_seen=0,
//   timeout_evt=0; all ready/valid outputs 0. Outputs are low combinationally while rst_n=0.
//  FSM IDLE->GRANT->(DRAIN|STOP)->IDLE.
//  IDLE: if any s_cmd_valid, grant the first requester after rr_last (wrapping), registered;
//   grant visible next cycle, rr_last<=winner. No ready is asserted in IDLE (1-cycle arbitration latency).
//  GRANT: zero-latency combinational mux for owner g:
//   m_cmd_*=s_cmd_*[g]; m_cmd_valid=s_cmd_valid[g]; s_cmd_ready[g]=m_cmd_ready; m_wr_*<=>s_wr_*[g];
//   m_rd_tvalid[g]=s_rd_tvalid; s_rd_tready=m_rd_tready[g]. Non-owner ready/valid outputs stay 0.
//   cmd handshake sets cmd_seen. Handshake with stop=1 -> DRAIN.
//  Watchdog: timer clears on any owner cmd/wr/rd handshake, otherwise increments. At timer==TIMEOUT-1 (TIMEOUT!=0):
//   timeout_evt=1 -> STOP if cmd_seen, else directly IDLE (grant<=0).
//  STOP: m_cmd_valid=1, stop=1, other flags 0, address 0; owner s_cmd_ready=0. Write and read paths stay routed
//   to the owner. Handshake -> DRAIN.
//  DRAIN: read/write routing kept, owner s_cmd_ready=0. Stay >=2 cycles, then exit when master_busy=0 and no
//   s_rd_tvalid pending -> IDLE, grant<=0, cmd_seen<=0, timer<=0.
//  Simultaneous: a new request arriving in the same cycle as release is arbitrated in IDLE next cycle;
//   the releasing port is lowest priority.
//  Backpressure: m_cmd_ready=0 holds the owner's s_cmd_ready=0; flags pass through unchanged.
//   Stable-while-valid is the requester's responsibility.
//  Reset mid-transaction: immediate return to reset values. i2c_master shares the reset domain.
// TESTING
//  1 Port0 cmd{addr 0x50, start, write, stop} + byte 0xA5 -> grant=0001 cycle+1; master sees 0x50/0xA5;
//    grant=0 after busy falls.
//  2 Ports 0 and 2 request continuously, single-stop transactions -> grant order 0,2,0,2; port1 never granted.
//  3 Port3 read with stop, master returns 0x3C tlast=1 -> only m_rd_tvalid[3]=1, tdata=0x3C; others 0.
//  4 TIMEOUT=16, port1 start+write no stop, then silent -> timeout_evt after 16 idle cycles, stop-only cmd,
//    then release.
//  5 m_cmd_ready held 0 for 10 cycles with port2 owning -> s_cmd_ready[2]=0 throughout; cmd accepted on release.
//  6 rst_n low during DRAIN -> grant=0, m_cmd_valid=0 at once; after release a port0+port1 request grants port0.

Source files
------------

// File: rtl/i2c_master_arbiter_if.sv
// Bus bundle between PORTS requesters, the arbiter and one shared i2c_master.
// The slave modport is the arbiter's view. The master modport is the view of
// the surrounding environment (requesters plus i2c_master).
interface i2c_master_arbiter_if #(
    parameter int PORTS = 4
);
    // requester command streams, port i in slice i
    logic [PORTS*7-1:0] s_cmd_address;
    logic [PORTS-1:0]   s_cmd_start;
    logic [PORTS-1:0]   s_cmd_read;
    logic [PORTS-1:0]   s_cmd_write;
    logic [PORTS-1:0]   s_cmd_write_multiple;
    logic [PORTS-1:0]   s_cmd_stop;
    logic [PORTS-1:0]   s_cmd_valid;
    logic [PORTS-1:0]   s_cmd_ready;

    // requester write-data streams
    logic [PORTS*8-1:0] s_wr_tdata;
    logic [PORTS-1:0]   s_wr_tvalid;
    logic [PORTS-1:0]   s_wr_tlast;
    logic [PORTS-1:0]   s_wr_tready;

    // read data back to requesters, data broadcast, handshake per port
    logic [7:0]         m_rd_tdata;
    logic               m_rd_tlast;
    logic [PORTS-1:0]   m_rd_tvalid;
    logic [PORTS-1:0]   m_rd_tready;

    // shared command towards i2c_master
    logic [6:0]         m_cmd_address;
    logic               m_cmd_start;
    logic               m_cmd_read;
    logic               m_cmd_write;
    logic               m_cmd_write_multiple;
    logic               m_cmd_stop;
    logic               m_cmd_valid;
    logic               m_cmd_ready;

    // shared write data towards i2c_master
    logic [7:0]         m_wr_tdata;
    logic               m_wr_tvalid;
    logic               m_wr_tlast;
    logic               m_wr_tready;

    // read data from i2c_master
    logic [7:0]         s_rd_tdata;
    logic               s_rd_tvalid;
    logic               s_rd_tlast;
    logic               s_rd_tready;

    logic               master_busy;

    modport slave (
        input  s_cmd_address, s_cmd_start, s_cmd_read, s_cmd_write, s_cmd_write_multiple,
               s_cmd_stop, s_cmd_valid,
        output s_cmd_ready,
        input  s_wr_tdata, s_wr_tvalid, s_wr_tlast,
        output s_wr_tready,
        output m_rd_tdata, m_rd_tlast, m_rd_tvalid,
        input  m_rd_tready,
        output m_cmd_address, m_cmd_start, m_cmd_read, m_cmd_write, m_cmd_write_multiple,
               m_cmd_stop, m_cmd_valid,
        input  m_cmd_ready,
        output m_wr_tdata, m_wr_tvalid, m_wr_tlast,
        input  m_wr_tready,
        input  s_rd_tdata, s_rd_tvalid, s_rd_tlast,
        output s_rd_tready,
        input  master_busy
    );

    modport master (
        output s_cmd_address, s_cmd_start, s_cmd_read, s_cmd_write, s_cmd_write_multiple,
               s_cmd_stop, s_cmd_valid,
        input  s_cmd_ready,
        output s_wr_tdata, s_wr_tvalid, s_wr_tlast,
        input  s_wr_tready,
        input  m_rd_tdata, m_rd_tlast, m_rd_tvalid,
        output m_rd_tready,
        input  m_cmd_address, m_cmd_start, m_cmd_read, m_cmd_write, m_cmd_write_multiple,
               m_cmd_stop, m_cmd_valid,
        output m_cmd_ready,
        input  m_wr_tdata, m_wr_tvalid, m_wr_tlast,
        output m_wr_tready,
        output s_rd_tdata, s_rd_tvalid, s_rd_tlast,
        input  s_rd_tready,
        output master_busy
    );
endinterface

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one i2c_master among PORTS requesters. The owner
// keeps the grant for a whole transaction (until its stop is accepted and the
// master goes idle). A watchdog reclaims the bus from a silent owner by
// issuing a stop-only command, or by simply dropping the grant if the owner
// never issued a command at all.
module i2c_master_arbiter #(
    parameter int PORTS   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    i2c_master_arbiter_if.slave bus,
    output logic [PORTS-1:0]    grant,
    output logic                timeout_evt
);
    localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [PW-1:0] LAST_PORT  = PW'(PORTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_STOP,
        ST_DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [PORTS-1:0] grant_q, grant_d;
    logic [PW-1:0]    owner_q, owner_d;
    logic [PW-1:0]    rr_last_q, rr_last_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             cmd_seen_q, cmd_seen_d;
    logic             timeout_evt_q, timeout_evt_d;
    logic             drain_cnt_q, drain_cnt_d;

    // per-port slices unpacked so the owner can be selected by index
    logic [6:0] port_addr  [PORTS];
    logic [7:0] port_wdata [PORTS];

    for (genvar p = 0; p < PORTS; p++) begin : g_unpack
        assign port_addr[p]  = bus.s_cmd_address[7*p +: 7];
        assign port_wdata[p] = bus.s_wr_tdata[8*p +: 8];
    end

    logic [PW-1:0] winner;
    logic          any_req;
    logic [PW-1:0] win_hi, win_lo;
    logic          found_hi;

    // round-robin pick: lowest requesting port above rr_last, else lowest overall
    always_comb begin
        win_hi   = '0;
        win_lo   = '0;
        found_hi = 1'b0;
        for (int i = PORTS - 1; i >= 0; i--) begin
            if (bus.s_cmd_valid[i]) begin
                if (PW'(i) > rr_last_q) begin
                    win_hi   = PW'(i);
                    found_hi = 1'b1;
                end else begin
                    win_lo = PW'(i);
                end
            end
        end
        winner  = found_hi ? win_hi : win_lo;
        any_req = |bus.s_cmd_valid;
    end

    logic [PORTS-1:0] s_cmd_ready_c, s_wr_tready_c, m_rd_tvalid_c;
    logic [6:0]       m_cmd_address_c;
    logic             m_cmd_start_c, m_cmd_read_c, m_cmd_write_c, m_cmd_wm_c, m_cmd_stop_c;
    logic             m_cmd_valid_c;
    logic [7:0]       m_wr_tdata_c;
    logic             m_wr_tvalid_c, m_wr_tlast_c, s_rd_tready_c;

    // owner routing mux: data paths follow the owner in every non-idle state,
    // the command path only in GRANT, STOP substitutes its own stop command
    always_comb begin
        s_cmd_ready_c   = '0;
        s_wr_tready_c   = '0;
        m_rd_tvalid_c   = '0;
        m_cmd_address_c = '0;
        m_cmd_start_c   = 1'b0;
        m_cmd_read_c    = 1'b0;
        m_cmd_write_c   = 1'b0;
        m_cmd_wm_c      = 1'b0;
        m_cmd_stop_c    = 1'b0;
        m_cmd_valid_c   = 1'b0;
        m_wr_tdata_c    = '0;
        m_wr_tvalid_c   = 1'b0;
        m_wr_tlast_c    = 1'b0;
        s_rd_tready_c   = 1'b0;
        if (state_q != ST_IDLE) begin
            m_wr_tdata_c           = port_wdata[owner_q];
            m_wr_tvalid_c          = bus.s_wr_tvalid[owner_q];
            m_wr_tlast_c           = bus.s_wr_tlast[owner_q];
            s_wr_tready_c[owner_q] = bus.m_wr_tready;
            m_rd_tvalid_c[owner_q] = bus.s_rd_tvalid;
            s_rd_tready_c          = bus.m_rd_tready[owner_q];
        end
        case (state_q)
            ST_GRANT: begin
                m_cmd_address_c        = port_addr[owner_q];
                m_cmd_start_c          = bus.s_cmd_start[owner_q];
                m_cmd_read_c           = bus.s_cmd_read[owner_q];
                m_cmd_write_c          = bus.s_cmd_write[owner_q];
                m_cmd_wm_c             = bus.s_cmd_write_multiple[owner_q];
                m_cmd_stop_c           = bus.s_cmd_stop[owner_q];
                m_cmd_valid_c          = bus.s_cmd_valid[owner_q];
                s_cmd_ready_c[owner_q] = bus.m_cmd_ready;
            end
            ST_STOP: begin
                m_cmd_stop_c  = 1'b1;
                m_cmd_valid_c = 1'b1;
            end
            default: begin
            end
        endcase
    end

    logic cmd_hs, wr_hs, rd_hs;
    assign cmd_hs = m_cmd_valid_c & bus.m_cmd_ready;
    assign wr_hs  = m_wr_tvalid_c & bus.m_wr_tready;
    assign rd_hs  = bus.s_rd_tvalid & s_rd_tready_c;

    // next-state logic for arbitration, ownership release and the watchdog
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        owner_d       = owner_q;
        rr_last_d     = rr_last_q;
        timer_d       = timer_q;
        cmd_seen_d    = cmd_seen_q;
        timeout_evt_d = 1'b0;
        drain_cnt_d   = drain_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d          = ST_GRANT;
                    owner_d          = winner;
                    rr_last_d        = winner;
                    grant_d          = '0;
                    grant_d[winner]  = 1'b1;
                    timer_d          = '0;
                    cmd_seen_d       = 1'b0;
                end
            end
            ST_GRANT: begin
                if (cmd_hs) begin
                    cmd_seen_d = 1'b1;
                end
                if (cmd_hs && m_cmd_stop_c) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = 1'b0;
                    timer_d     = '0;
                end else if (cmd_hs || wr_hs || rd_hs) begin
                    timer_d = '0;
                end else if ((TIMEOUT != 0) && (timer_q == TIMER_LAST)) begin
                    timeout_evt_d = 1'b1;
                    timer_d       = '0;
                    if (cmd_seen_q) begin
                        state_d = ST_STOP;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_STOP: begin
                if (cmd_hs) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (!drain_cnt_q) begin
                    drain_cnt_d = 1'b1;
                end else if (!bus.master_busy && !bus.s_rd_tvalid) begin
                    state_d    = ST_IDLE;
                    grant_d    = '0;
                    cmd_seen_d = 1'b0;
                    timer_d    = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // state register with asynchronous return to the reset values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            owner_q       <= '0;
            rr_last_q     <= LAST_PORT;
            timer_q       <= '0;
            cmd_seen_q    <= 1'b0;
            timeout_evt_q <= 1'b0;
            drain_cnt_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            owner_q       <= owner_d;
            rr_last_q     <= rr_last_d;
            timer_q       <= timer_d;
            cmd_seen_q    <= cmd_seen_d;
            timeout_evt_q <= timeout_evt_d;
            drain_cnt_q   <= drain_cnt_d;
        end
    end

    assign grant       = grant_q;
    assign timeout_evt = timeout_evt_q;

    assign bus.s_cmd_ready          = s_cmd_ready_c;
    assign bus.s_wr_tready          = s_wr_tready_c;
    assign bus.m_rd_tvalid          = m_rd_tvalid_c;
    assign bus.m_rd_tdata           = bus.s_rd_tdata;
    assign bus.m_rd_tlast           = bus.s_rd_tlast;
    assign bus.m_cmd_address        = m_cmd_address_c;
    assign bus.m_cmd_start          = m_cmd_start_c;
    assign bus.m_cmd_read           = m_cmd_read_c;
    assign bus.m_cmd_write          = m_cmd_write_c;
    assign bus.m_cmd_write_multiple = m_cmd_wm_c;
    assign bus.m_cmd_stop           = m_cmd_stop_c;
    assign bus.m_cmd_valid          = m_cmd_valid_c;
    assign bus.m_wr_tdata           = m_wr_tdata_c;
    assign bus.m_wr_tvalid          = m_wr_tvalid_c;
    assign bus.m_wr_tlast           = m_wr_tlast_c;
    assign bus.s_rd_tready          = s_rd_tready_c;
endmodule
